// File: rtl/verbus_arbiter_if.sv
// Bundle of the two manager ports and the shared-memory port of the arbiter.
// The slave modport is the arbiter's view; master is the view of whoever drives managers and memory.
interface verbus_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32
);
  logic                     m0_valid;
  logic [ADDRESS_WIDTH-1:0] m0_address;
  logic [3:0]               m0_wstrobe;
  logic [31:0]              m0_wdata;
  logic                     m0_ready;
  logic [31:0]              m0_rdata;

  logic                     m1_valid;
  logic [ADDRESS_WIDTH-1:0] m1_address;
  logic [3:0]               m1_wstrobe;
  logic [31:0]              m1_wdata;
  logic                     m1_ready;
  logic [31:0]              m1_rdata;

  logic                     s_valid;
  logic [ADDRESS_WIDTH-1:0] s_address;
  logic [3:0]               s_wstrobe;
  logic [31:0]              s_wdata;
  logic                     s_ready;
  logic [31:0]              s_rdata;

  modport slave (
    input  m0_valid, m0_address, m0_wstrobe, m0_wdata,
    input  m1_valid, m1_address, m1_wstrobe, m1_wdata,
    input  s_ready, s_rdata,
    output m0_ready, m0_rdata, m1_ready, m1_rdata,
    output s_valid, s_address, s_wstrobe, s_wdata
  );

  modport master (
    output m0_valid, m0_address, m0_wstrobe, m0_wdata,
    output m1_valid, m1_address, m1_wstrobe, m1_wdata,
    output s_ready, s_rdata,
    input  m0_ready, m0_rdata, m1_ready, m1_rdata,
    input  s_valid, s_address, s_wstrobe, s_wdata
  );
endinterface

// File: rtl/verbus_arbiter.sv
// Two-manager arbiter for a single shared memory port: zero-latency request mux,
// lock on multi-cycle transfers, round-robin or fixed (m1) priority on contention.
module verbus_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter bit ROUND_ROBIN   = 1'b1
) (
  input logic             clk,
  input logic             reset,
  verbus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last_grant, last_grant_nxt;
  logic   gnt0, gnt1;
  logic   done0, done1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    gnt0           = 1'b0;
    gnt1           = 1'b0;
    state_nxt      = state;
    last_grant_nxt = last_grant;
    bus.s_valid    = 1'b0;
    bus.s_address  = '0;
    bus.s_wstrobe  = 4'b0000;
    bus.s_wdata    = 32'h0;

    // Grant is suppressed while reset is held so nothing reaches memory.
    if (reset) begin
      case (state)
        OWN0:    gnt0 = 1'b1;
        OWN1:    gnt1 = 1'b1;
        default: begin
          if (bus.m0_valid && bus.m1_valid) begin
            if (ROUND_ROBIN) begin
              gnt0 = last_grant;
              gnt1 = !last_grant;
            end else begin
              gnt1 = 1'b1;
            end
          end else begin
            gnt0 = bus.m0_valid;
            gnt1 = bus.m1_valid;
          end
        end
      endcase
    end

    done0 = gnt0 && bus.m0_valid && bus.s_ready;
    done1 = gnt1 && bus.m1_valid && bus.s_ready;

    if (gnt0) begin
      bus.s_valid   = bus.m0_valid;
      bus.s_address = bus.m0_address;
      bus.s_wstrobe = bus.m0_wstrobe;
      bus.s_wdata   = bus.m0_wdata;
    end else if (gnt1) begin
      bus.s_valid   = bus.m1_valid;
      bus.s_address = bus.m1_address;
      bus.s_wstrobe = bus.m1_wstrobe;
      bus.s_wdata   = bus.m1_wdata;
    end

    if (done0) begin
      last_grant_nxt = 1'b0;
    end else if (done1) begin
      last_grant_nxt = 1'b1;
    end

    // A lock is released on completion or if the owner abandons its request.
    case (state)
      IDLE: begin
        if (gnt0 && !bus.s_ready) begin
          state_nxt = OWN0;
        end else if (gnt1 && !bus.s_ready) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!bus.m0_valid || bus.s_ready) state_nxt = IDLE;
      end
      OWN1: begin
        if (!bus.m1_valid || bus.s_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.m0_ready = gnt0 && bus.s_ready;
  assign bus.m1_ready = gnt1 && bus.s_ready;
  assign bus.m0_rdata = bus.s_rdata;
  assign bus.m1_rdata = bus.s_rdata;

endmodule

// File: tb/tb_verbus_arbiter.sv
// Randomised and directed stimulus for round-robin and fixed-priority arbiters,
// checked by a queue-based scoreboard against a transaction-level ownership model.
module tb_verbus_arbiter;

  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  verbus_arbiter_if #(.ADDRESS_WIDTH(32)) bus_rr ();
  verbus_arbiter_if #(.ADDRESS_WIDTH(32)) bus_fx ();

  verbus_arbiter #(.ADDRESS_WIDTH(32), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .reset(reset), .bus(bus_rr.slave)
  );
  verbus_arbiter #(.ADDRESS_WIDTH(32), .ROUND_ROBIN(1'b0)) u_fx (
    .clk(clk), .reset(reset), .bus(bus_fx.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        sv;
    logic [31:0] addr;
    logic [3:0]  ws;
    logic [31:0] wd;
    logic        r0;
    logic        r1;
    logic [31:0] rd;
  } exp_t;

  exp_t q_rr[$];
  exp_t q_fx[$];

  // Model state: which manager holds the bus (-1 = nobody) and who last completed.
  int owner [2] = '{-1, -1};
  int last  [2] = '{1, 1};

  function automatic int model_grant(input int k, input logic rst, input logic v0, input logic v1);
    if (!rst)            return -1;
    if (owner[k] >= 0)   return owner[k];
    if (v0 && v1)        return (k == 0) ? ((last[k] == 0) ? 1 : 0) : 1;
    if (v0)              return 0;
    if (v1)              return 1;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic v0, input logic v1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [3:0] ws0, input logic [3:0] ws1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic srdy, input logic [31:0] srd);
    int   g [2];
    exp_t e;
    logic        vv  [2];
    logic [31:0] aa  [2];
    logic [3:0]  ww  [2];
    logic [31:0] dd  [2];
    vv = '{v0, v1}; aa = '{a0, a1}; ww = '{ws0, ws1}; dd = '{wd0, wd1};
    reset = rst;
    bus_rr.m0_valid = v0;  bus_rr.m0_address = a0; bus_rr.m0_wstrobe = ws0; bus_rr.m0_wdata = wd0;
    bus_rr.m1_valid = v1;  bus_rr.m1_address = a1; bus_rr.m1_wstrobe = ws1; bus_rr.m1_wdata = wd1;
    bus_rr.s_ready  = srdy; bus_rr.s_rdata = srd;
    bus_fx.m0_valid = v0;  bus_fx.m0_address = a0; bus_fx.m0_wstrobe = ws0; bus_fx.m0_wdata = wd0;
    bus_fx.m1_valid = v1;  bus_fx.m1_address = a1; bus_fx.m1_wstrobe = ws1; bus_fx.m1_wdata = wd1;
    bus_fx.s_ready  = srdy; bus_fx.s_rdata = srd;
    for (int k = 0; k < 2; k++) begin
      g[k] = model_grant(k, rst, v0, v1);
      e = '0;
      e.rd = srd;
      if (g[k] >= 0) begin
        e.sv   = vv[g[k]];
        e.addr = aa[g[k]];
        e.ws   = ww[g[k]];
        e.wd   = dd[g[k]];
        e.r0   = (g[k] == 0) && srdy;
        e.r1   = (g[k] == 1) && srdy;
      end
      if (k == 0) q_rr.push_back(e);
      else        q_fx.push_back(e);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        owner[k] = -1;
        last[k]  = 1;
      end else if (g[k] >= 0) begin
        if (vv[g[k]] && srdy) last[k] = g[k];
        owner[k] = (vv[g[k]] && !srdy) ? g[k] : -1;
      end
    end
    #1;
  endtask

  task automatic idle(input logic rst);
    drive(rst, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  // Scoreboard monitor: one expected record per driven cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q_rr.size() > 0) begin
        e = q_rr.pop_front();
        chk("rr s_valid",   {31'h0, bus_rr.s_valid},  {31'h0, e.sv});
        chk("rr s_address", bus_rr.s_address,         e.addr);
        chk("rr s_wstrobe", {28'h0, bus_rr.s_wstrobe}, {28'h0, e.ws});
        chk("rr s_wdata",   bus_rr.s_wdata,           e.wd);
        chk("rr m0_ready",  {31'h0, bus_rr.m0_ready}, {31'h0, e.r0});
        chk("rr m1_ready",  {31'h0, bus_rr.m1_ready}, {31'h0, e.r1});
        chk("rr m0_rdata",  bus_rr.m0_rdata,          e.rd);
        chk("rr m1_rdata",  bus_rr.m1_rdata,          e.rd);
      end
      if (q_fx.size() > 0) begin
        e = q_fx.pop_front();
        chk("fx s_valid",   {31'h0, bus_fx.s_valid},  {31'h0, e.sv});
        chk("fx s_address", bus_fx.s_address,         e.addr);
        chk("fx s_wstrobe", {28'h0, bus_fx.s_wstrobe}, {28'h0, e.ws});
        chk("fx s_wdata",   bus_fx.s_wdata,           e.wd);
        chk("fx m0_ready",  {31'h0, bus_fx.m0_ready}, {31'h0, e.r0});
        chk("fx m1_ready",  {31'h0, bus_fx.m1_ready}, {31'h0, e.r1});
        chk("fx m0_rdata",  bus_fx.m0_rdata,          e.rd);
        chk("fx m1_rdata",  bus_fx.m1_rdata,          e.rd);
      end
    end
  end

  initial begin
    logic        v0, v1, srdy, rst;
    logic [31:0] a0, a1, wd0, wd1;
    logic [3:0]  ws0, ws1;
    reset = 1'b0;
    idle(1'b0);
    @(posedge clk);
    #1;

    // Reset held with both requests high: nothing may be granted.
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h20, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h55);
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'h20, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h66);

    // Single m0 read completing at once, then m1 alone to show IDLE was kept.
    drive(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hCAFE0001);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h200, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'hCAFE0002);

    // Contention after reset: rr alternates m0,m1,m0,m1; fixed gives m1 every cycle.
    idle(1'b0);
    for (int i = 0; i < 4; i++)
      drive(1'b1, 1'b1, 1'b1, 32'h1000 + i, 32'h2000 + i, 4'h0, 4'hF, 32'h0, 32'h11 * i, 1'b1, 32'h0 + i);

    // Multi-cycle m0 transfer with m1 waiting.
    idle(1'b0);
    drive(1'b1, 1'b1, 1'b0, 32'hA0, 32'hB0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h1);
    drive(1'b1, 1'b1, 1'b1, 32'hA0, 32'hB0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h2);
    drive(1'b1, 1'b1, 1'b1, 32'hA0, 32'hB0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h3);
    drive(1'b1, 1'b0, 1'b1, 32'hA0, 32'hB0, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h4);

    // m1 write passes strobes and data through unchanged.
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h40, 4'h0, 4'b0011, 32'h0, 32'hDEADBEEF, 1'b1, 32'h0);

    // Reset while m1 owns the bus, then contention restarts with m0 first.
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h80, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 32'h70, 32'h80, 4'h0, 4'h0, 32'h0, 32'h0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h70, 32'h80, 4'h0, 4'h0, 32'h0, 32'h0, 1'b1, 32'h9);

    // Random traffic, including stalls, writes, dropped requests and reset pulses.
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 49) != 0);
      v0   = ($urandom_range(0, 3) != 0);
      v1   = ($urandom_range(0, 3) != 0);
      srdy = ($urandom_range(0, 4) > 1);
      a0   = $urandom;  a1  = $urandom;
      wd0  = $urandom;  wd1 = $urandom;
      ws0  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      ws1  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      drive(rst, v0, v1, a0, a1, ws0, ws1, wd0, wd1, srdy, $urandom);
    end

    idle(1'b1);
    @(posedge clk);
    #1;
    chk("rr queue drained", q_rr.size(), 32'd0);
    chk("fx queue drained", q_fx.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/verbus_arbiter.md
VERBUS_ARBITER -- requirements
Module: verbus_arbiter

Interface
REQ-001 The block SHALL take parameter ADDRESS_WIDTH, default 32, width of all address ports.
REQ-002 The block SHALL take parameter ROUND_ROBIN, default 1; 1 = alternate on contention, 0 = fixed priority to m1.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 m0_valid, m1_valid  in  1  manager request (m0 = instruction side, m1 = data side).
REQ-007 m0_address, m1_address  in  ADDRESS_WIDTH  byte address.
REQ-008 m0_wstrobe, m1_wstrobe  in  4  byte write enables; all zero = read.
REQ-009 m0_wdata, m1_wdata  in  32  write data.
REQ-010 m0_ready, m1_ready  out  1  transfer completes this cycle.
REQ-011 m0_rdata, m1_rdata  out  32  read data.
REQ-012 s_valid  out  1  request to the shared memory.
REQ-013 s_address  out  ADDRESS_WIDTH;  s_wstrobe  out  4;  s_wdata  out  32  muxed request.
REQ-014 s_ready  in  1;  s_rdata  in  32  memory response.

Function
REQ-015 A transfer SHALL complete in a cycle where the granted manager's valid and s_ready are both high.
REQ-016 State SHALL be one of IDLE, OWN0, OWN1; plus register last_grant (0 or 1).
REQ-017 In IDLE, grant SHALL be combinational: only m0_valid -> m0; only m1_valid -> m1; neither -> none.
REQ-018 In IDLE with both valid: ROUND_ROBIN=1 -> manager != last_grant; ROUND_ROBIN=0 -> m1.
REQ-019 In OWNx, grant SHALL be x regardless of the other manager's valid.
REQ-020 s_valid, s_address, s_wstrobe, s_wdata SHALL equal the granted manager's signals, same cycle (zero added latency).
REQ-021 With no grant, s_valid SHALL be 0, s_wstrobe 0, s_address and s_wdata 0.
REQ-022 Granted manager's ready SHALL equal s_ready; non-granted manager's ready SHALL be 0.
REQ-023 m0_rdata and m1_rdata SHALL both equal s_rdata (broadcast, unregistered).
REQ-024 IDLE -> OWNx when x is granted and s_ready=0 (lock for multi-cycle transfer).
REQ-025 IDLE stays IDLE when the granted transfer completes in the same cycle.
REQ-026 OWNx -> IDLE on completion (mx_valid=1, s_ready=1).
REQ-027 OWNx -> IDLE if mx_valid drops without completion (protocol violation, defensive); no transfer counted.
REQ-028 last_grant SHALL update to x on every completed transfer of x, and only then.
REQ-029 A manager SHALL never be granted and completed twice in a row while the other has been waiting with valid high, when ROUND_ROBIN=1.
REQ-030 Writes SHALL complete when s_ready is high; the arbiter adds no write buffering.

Reset
REQ-031 On reset low: state=IDLE, last_grant=1 (m0 wins first contention); effective immediately, asynchronously.
REQ-032 During reset, s_valid, m0_ready, m1_ready SHALL be 0, regardless of input valids.
REQ-033 Reset asserted in OWNx SHALL abort the lock; after release, arbitration restarts from IDLE.

Verification
REQ-034 Single m0 read, s_ready=1 same cycle, address 0x100 -> s_address=0x100, m0_ready=1, m1_ready=0, state stays IDLE.
REQ-035 Both valid after reset, ROUND_ROBIN=1, s_ready=1 every cycle -> completions m0, m1, m0, m1 on four consecutive cycles.
REQ-036 Both valid, ROUND_ROBIN=0 -> m1 completes every cycle; m0_ready stays 0.
REQ-037 m0 granted with s_ready=0 for 2 cycles, m1 asserts valid in cycle 1 -> s_address stays m0_address until m0_ready=1 in cycle 3; m1 granted cycle 4.
REQ-038 m1 write wstrobe=0b0011 wdata=0xDEADBEEF address 0x40 -> s_wstrobe=0b0011, s_wdata=0xDEADBEEF, s_address=0x40 same cycle.
REQ-039 Reset pulsed low while in OWN1 -> s_valid=0 immediately; after release with both valid, m0 granted first.
